// File: rtl/inst_dispatch_buffer.sv
// Instruction dispatch buffer: DEPTH-entry in-order FIFO in front of the matrix core,
// issuing one instruction per handshake while capping issued-but-incomplete work at MAX_OUT.
module inst_dispatch_buffer #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int INST_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [INST_W-1:0]        inst_i,
  input  logic                     inst_valid_i,
  output logic                     inst_ready_o,
  output logic [INST_W-1:0]        issue_inst_o,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  input  logic                     exec_done_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     idle_o,
  output logic                     err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
  localparam logic [OW-1:0] MAXO_V  = OW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [OW-1:0]     out_q, out_d;
  logic              err_q, err_d;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] mem_d [DEPTH];
  logic              push, fire;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a full slot.
  assign inst_ready_o  = rst_i && (count_q != DEPTH_V);
  assign issue_valid_o = (state_q == ISSUE);
  assign issue_inst_o  = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign idle_o        = (count_q == '0) && (out_q == '0);
  assign err_o         = err_q;

  always_comb begin
    push     = inst_valid_i && inst_ready_o;
    fire     = issue_valid_o && issue_ready_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    out_d    = out_q;
    err_d    = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = inst_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (fire) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fire && !exec_done_i) begin
      out_d = out_q + OW'(1);
    end else if (!fire && exec_done_i) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OW'(1);
    end
  end

  // All decisions use next-cycle occupancy and outstanding so a push is offered the very next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = (out_d < MAXO_V) ? ISSUE : WAIT;
      end
      ISSUE: begin
        if (fire) begin
          if (out_d == MAXO_V)     state_d = WAIT;
          else if (count_d == '0)  state_d = IDLE;
        end
      end
      WAIT: begin
        if (out_d < MAXO_V) state_d = (count_d != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_inst_dispatch_buffer.sv
// Directed bench for inst_dispatch_buffer: driver queues expected issues, a negedge monitor
// pops and compares every fired instruction and checks the offer stays stable until taken.
module tb_inst_dispatch_buffer;
  localparam int DEPTH = 4, MAX_OUT = 2, INST_W = 32;

  logic              clk_i = 0, rst_i = 0;
  logic [INST_W-1:0] inst_i = '0;
  logic              inst_valid_i = 0, issue_ready_i = 0, exec_done_i = 0;
  logic              inst_ready_o, issue_valid_o, idle_o, err_o;
  logic [INST_W-1:0] issue_inst_o;
  logic [$clog2(DEPTH):0] count_o;

  inst_dispatch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .INST_W(INST_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .issue_inst_o(issue_inst_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .exec_done_i(exec_done_i), .count_o(count_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_fail = 0, inflight = 0;
  logic [INST_W-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic push_one(input logic [INST_W-1:0] d, input logic exp_acc);
    inst_i = d; inst_valid_i = 1;
    chk("inst_ready", 32'(inst_ready_o), 32'(exp_acc));
    if (exp_acc) sb.push_back(d);
    tick();
    inst_valid_i = 0;
  endtask

  task automatic drain();
    bit done = 0;
    issue_ready_i = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      exec_done_i = (inflight > 0);
      tick();
      if (exec_done_i) inflight--;
      exec_done_i = 0;
      if (idle_o && sb.size() == 0) done = 1;
    end
    chk("drain_idle", 32'(done), 32'd1);
    issue_ready_i = 0;
  endtask

  // Monitor: compare fired instructions against scoreboard, check offer stability
  logic              prev_valid = 0, prev_fire = 0;
  logic [INST_W-1:0] prev_inst = '0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_valid <= 0; prev_fire <= 0;
    end else begin
      if (prev_valid && !prev_fire) begin
        chk("valid_held", 32'(issue_valid_o), 32'd1);
        chk("inst_stable", issue_inst_o, prev_inst);
      end
      if (issue_valid_o && issue_ready_i) begin
        if (sb.size() == 0) chk("unexpected_issue", issue_inst_o, 32'hDEAD_BEEF);
        else chk("issue_inst", issue_inst_o, sb.pop_front());
        inflight++;
      end
      prev_valid <= issue_valid_o;
      prev_fire  <= issue_valid_o && issue_ready_i;
      prev_inst  <= issue_inst_o;
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(inst_ready_o), 32'd0);
    chk("rst_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_i = 1;
    tick();
    chk("ready_after_rst", 32'(inst_ready_o), 32'd1);

    // 1: single instruction offered the cycle after acceptance
    issue_ready_i = 1;
    push_one(32'hA5, 1);
    chk("t1_valid", 32'(issue_valid_o), 32'd1);
    chk("t1_count", 32'(count_o), 32'd1);
    chk("t1_idle", 32'(idle_o), 32'd0);
    tick();
    chk("t1_valid_after_fire", 32'(issue_valid_o), 32'd0);
    chk("t1_count_after_fire", 32'(count_o), 32'd0);
    chk("t1_idle_inflight", 32'(idle_o), 32'd0);
    exec_done_i = 1; tick(); exec_done_i = 0; inflight--;
    chk("t1_idle_done", 32'(idle_o), 32'd1);
    chk("t1_err", 32'(err_o), 32'd0);

    // 2: fill to DEPTH with core stalled; fifth word held off
    issue_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_count", 32'(count_o), 32'(i < 4 ? i : 4));
      push_one(32'h10 + 32'(i), i < 4);
    end
    chk("t2_count_full", 32'(count_o), 32'd4);
    chk("t2_ready_full", 32'(inst_ready_o), 32'd0);
    drain();

    // 3: MAX_OUT throttling
    for (int i = 0; i < 3; i++) push_one(32'h30 + 32'(i), 1);
    issue_ready_i = 1;
    tick(); tick();
    chk("t3_wait_valid", 32'(issue_valid_o), 32'd0);
    chk("t3_wait_count", 32'(count_o), 32'd1);
    tick();
    chk("t3_still_wait", 32'(issue_valid_o), 32'd0);
    exec_done_i = 1; tick(); exec_done_i = 0; inflight--;
    chk("t3_reissue", 32'(issue_valid_o), 32'd1);
    drain();

    // 4: full FIFO, pop and push same cycle: push refused
    for (int i = 0; i < 4; i++) push_one(32'h40 + 32'(i), 1);
    issue_ready_i = 1;
    push_one(32'h44, 0);
    chk("t4_count", 32'(count_o), 32'd3);
    chk("t4_ready", 32'(inst_ready_o), 32'd1);
    drain();

    // 5: spurious completion
    exec_done_i = 1; tick(); exec_done_i = 0;
    chk("t5_err", 32'(err_o), 32'd1);
    chk("t5_idle", 32'(idle_o), 32'd1);
    tick(); tick();
    chk("t5_err_sticky", 32'(err_o), 32'd1);

    // 6: reset mid-operation, then refill
    for (int i = 0; i < 4; i++) push_one(32'h60 + 32'(i), 1);
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    chk("t6_pre_count", 32'(count_o), 32'd3);
    chk("t6_pre_idle", 32'(idle_o), 32'd0);
    rst_i = 0; sb.delete(); inflight = 0;
    tick();
    chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_idle", 32'(idle_o), 32'd1);
    chk("t6_rst_valid", 32'(issue_valid_o), 32'd0);
    chk("t6_rst_ready", 32'(inst_ready_o), 32'd0);
    rst_i = 1; tick();
    chk("t6_err_clr", 32'(err_o), 32'd0);
    chk("t6_no_issue", 32'(issue_valid_o), 32'd0);
    chk("t6_ready", 32'(inst_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) push_one(32'h70 + 32'(i), 1);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
